// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60) and the coordinate type used by the
// renderer, object and collider blocks.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster stream from the timing generator: coordinates, blank, sync pins and
// the pixel/frame strobes.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  coord_t x;
  coord_t y;
  logic   blank;
  logic   hsync;
  logic   vsync;
  logic   pixel_tick;
  logic   frame_tick;

  modport master (output x, y, blank, hsync, vsync, pixel_tick, frame_tick);
  modport slave  (input  x, y, blank, hsync, vsync, pixel_tick, frame_tick);

endinterface

// File: rtl/pixel_en_div.sv
// System-clock divider: pix_en_o is high in the last clk of every CLK_DIV-clk
// pixel period.
module pixel_en_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic pix_en_o
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q + DivW'(1);
    // Also covers CLK_DIV==1, where DivLast is 0 and div stays parked at 0.
    if (div_q == DivLast) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign pix_en_o = (div_q == DivLast);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator; every output is registered one clk behind the
// div/hcnt/vcnt counters so the whole stream stays coherent.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
  parameter int unsigned SYNC_POL = 0
) (
  input  logic              clk,
  input  logic              reset,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t HLast      = COORD_W'(HTotal - 1);
  localparam coord_t VLast      = COORD_W'(VTotal - 1);
  localparam coord_t HAct       = COORD_W'(H_ACTIVE);
  localparam coord_t VAct       = COORD_W'(V_ACTIVE);
  localparam coord_t HSyncStart = COORD_W'(H_ACTIVE + H_FP);
  localparam coord_t HSyncEnd   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VSyncStart = COORD_W'(V_ACTIVE + V_FP);
  localparam coord_t VSyncEnd   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic   SyncOn     = (SYNC_POL != 0);

  logic   pix_en;
  coord_t hcnt_q, hcnt_d;
  coord_t vcnt_q, vcnt_d;
  coord_t x_q, y_q;
  logic   blank_q, hsync_q, vsync_q, pixel_tick_q, frame_tick_q;
  logic   h_last, v_last;

  pixel_en_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_en_div (
    .clk      (clk),
    .reset    (reset),
    .pix_en_o (pix_en)
  );

  assign h_last = (hcnt_q == HLast);
  assign v_last = (vcnt_q == VLast);

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_en) begin
      if (h_last) begin
        hcnt_d = '0;
        vcnt_d = v_last ? '0 : vcnt_q + COORD_W'(1);
      end else begin
        hcnt_d = hcnt_q + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      blank_q      <= 1'b1;
      hsync_q      <= ~SyncOn;
      vsync_q      <= ~SyncOn;
      pixel_tick_q <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      // Output stage decodes the pre-advance counters, hence the 1-clk lag.
      x_q          <= hcnt_q;
      y_q          <= vcnt_q;
      blank_q      <= (hcnt_q >= HAct) || (vcnt_q >= VAct);
      hsync_q      <= ((hcnt_q >= HSyncStart) && (hcnt_q < HSyncEnd)) ? SyncOn : ~SyncOn;
      vsync_q      <= ((vcnt_q >= VSyncStart) && (vcnt_q < VSyncEnd)) ? SyncOn : ~SyncOn;
      pixel_tick_q <= pix_en;
      frame_tick_q <= pix_en && h_last && v_last;
    end
  end

  assign vga.x          = x_q;
  assign vga.y          = y_q;
  assign vga.blank      = blank_q;
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.pixel_tick = pixel_tick_q;
  assign vga.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations run side by side with random
// resets, each compared every clk against a closed-form raster model.
module tb_vga_timing_gen;

  // Config A: default 640x480, CLK_DIV=4, active-low sync.
  // Config B: tiny raster, CLK_DIV=3, active-high sync.
  // Config C: tiny raster, CLK_DIV=1, active-low sync.
  localparam int BD = 3, BHA = 8, BHF = 2, BHS = 3, BHB = 2, BVA = 4, BVF = 1, BVS = 2, BVB = 1;
  localparam int CD = 1, CHA = 8, CHF = 1, CHS = 2, CHB = 1, CVA = 4, CVF = 1, CVS = 1, CVB = 1;

  logic clk;
  logic rst_a, rst_b, rst_c;
  int   c_a, c_b, c_c;
  int   n_checks, n_errors;

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();
  vga_timing_gen_if if_c ();

  vga_timing_gen u_dut_a (
    .clk   (clk),
    .reset (rst_a),
    .vga   (if_a.master)
  );

  vga_timing_gen #(
    .CLK_DIV (BD), .H_ACTIVE (BHA), .H_FP (BHF), .H_SYNC (BHS), .H_BP (BHB),
    .V_ACTIVE (BVA), .V_FP (BVF), .V_SYNC (BVS), .V_BP (BVB), .SYNC_POL (1)
  ) u_dut_b (
    .clk   (clk),
    .reset (rst_b),
    .vga   (if_b.master)
  );

  vga_timing_gen #(
    .CLK_DIV (CD), .H_ACTIVE (CHA), .H_FP (CHF), .H_SYNC (CHS), .H_BP (CHB),
    .V_ACTIVE (CVA), .V_FP (CVF), .V_SYNC (CVS), .V_BP (CVB), .SYNC_POL (0)
  ) u_dut_c (
    .clk   (clk),
    .reset (rst_c),
    .vga   (if_c.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // c = clk edges since the last reset edge; the pixel shown after edge c is
  // pixel number (c-1)/d of the raster, scanned row-major.
  task automatic check_dut(input string nm, input int c, input int d,
                           input int ha, input int hf, input int hs, input int hb,
                           input int va, input int vf, input int vs, input int vb,
                           input int pol,
                           input int ox, input int oy, input int ob, input int ohs,
                           input int ovs, input int opt, input int oft);
    int ht, vt, p, ex, ey, eb, ehs, evs, ept, eft;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    if (c == 0) begin
      ex = 0; ey = 0; eb = 1; ehs = 1 - pol; evs = 1 - pol; ept = 0; eft = 0;
    end else begin
      p   = (c - 1) / d;
      ex  = p % ht;
      ey  = (p / ht) % vt;
      eb  = (ex >= ha || ey >= va) ? 1 : 0;
      ehs = (ex >= ha + hf && ex < ha + hf + hs) ? pol : 1 - pol;
      evs = (ey >= va + vf && ey < va + vf + vs) ? pol : 1 - pol;
      ept = (((c - 1) % d) == d - 1) ? 1 : 0;
      eft = (ept == 1 && ex == ht - 1 && ey == vt - 1) ? 1 : 0;
    end
    check_eq($sformatf("%s.x c=%0d", nm, c), ox, ex);
    check_eq($sformatf("%s.y c=%0d", nm, c), oy, ey);
    check_eq($sformatf("%s.blank c=%0d", nm, c), ob, eb);
    check_eq($sformatf("%s.hsync c=%0d", nm, c), ohs, ehs);
    check_eq($sformatf("%s.vsync c=%0d", nm, c), ovs, evs);
    check_eq($sformatf("%s.pixel_tick c=%0d", nm, c), opt, ept);
    check_eq($sformatf("%s.frame_tick c=%0d", nm, c), oft, eft);
  endtask

  task automatic step_and_check();
    @(posedge clk);
    c_a = rst_a ? c_a + 1 : 0;
    c_b = rst_b ? c_b + 1 : 0;
    c_c = rst_c ? c_c + 1 : 0;
    @(negedge clk);
    check_dut("A", c_a, 4, 640, 16, 96, 48, 480, 10, 2, 33, 0,
              int'(if_a.x), int'(if_a.y), int'(if_a.blank), int'(if_a.hsync),
              int'(if_a.vsync), int'(if_a.pixel_tick), int'(if_a.frame_tick));
    check_dut("B", c_b, BD, BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB, 1,
              int'(if_b.x), int'(if_b.y), int'(if_b.blank), int'(if_b.hsync),
              int'(if_b.vsync), int'(if_b.pixel_tick), int'(if_b.frame_tick));
    check_dut("C", c_c, CD, CHA, CHF, CHS, CHB, CVA, CVF, CVS, CVB, 0,
              int'(if_c.x), int'(if_c.y), int'(if_c.blank), int'(if_c.hsync),
              int'(if_c.vsync), int'(if_c.pixel_tick), int'(if_c.frame_tick));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    c_a = 0;
    c_b = 0;
    c_c = 0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    repeat (3) step_and_check();
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    // Clean run first: config A sees two full lines, B and C many frames.
    repeat (8000) step_and_check();
    // Then sporadic 1-clk (occasionally longer) resets at arbitrary phases.
    for (int i = 0; i < 12000; i++) begin
      rst_a = ($urandom_range(0, 299) != 0);
      rst_b = ($urandom_range(0, 199) != 0);
      rst_c = ($urandom_range(0, 149) != 0);
      step_and_check();
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
